// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle MIPS-subset control unit.
//
// Registered FSM FETCH(0) -> DECODE(1) -> EXE(2) -> MEM(3) -> WB(4). The
// instruction fields drive a combinational decode. All outputs are Moore/Mealy
// combinational from the current state plus opcode/funct/zero/mem_rdy.
//
// Optional build macro: MC_CTRL_MEMRDY_EN -- FETCH and MEM stall while
// mem_rdy=0 and gate their write enables with mem_rdy. Without it mem_rdy is
// ignored.
//
// Ports
//   clk            sole clock, rising edge
//   reset          synchronous active-low reset
//   opcode, funct  instruction fields (stable from DECODE onward)
//   zero           ALU equality flag (beq)
//   mem_rdy        memory ready (only with MC_CTRL_MEMRDY_EN)
//   PCWr, IRWr, RegWr, MemWr   write enables
//   ExtOp          00 zero, 01 sign, 10 imm<<16, 11 sign<<2
//   ALUOp          00 add, 01 sub, 10 or, 11 pass B
//   ALUSrc         0 rt, 1 ext
//   RegDst         00 rt, 01 rd, 10 $31
//   WDSel          00 ALU, 01 mem, 10 PC
//   NPCOp          00 PC+4, 01 branch, 10 jump target, 11 rs
//   state          current FSM state
//   illegal        one-cycle pulse in DECODE for an unsupported instruction
// ---------------------------------------------------------------------------
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [1:0] ExtOp,
    output logic [1:0] ALUOp,
    output logic       ALUSrc,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic [1:0] NPCOp,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e state_q, state_d;
    state_e st_eff;
    logic   rdy;

`ifdef MC_CTRL_MEMRDY_EN
    assign rdy = mem_rdy;
`else
    logic mem_rdy_unused;
    assign mem_rdy_unused = mem_rdy;
    assign rdy = 1'b1;
`endif

    // ---------------- instruction decode ----------------
    logic is_r, is_addu, is_subu, is_jr;
    logic is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
    logic supported;

    always_comb begin
        is_r      = (opcode == 6'b000000);
        is_addu   = is_r && (funct == 6'b100001);
        is_subu   = is_r && (funct == 6'b100011);
        is_jr     = is_r && (funct == 6'b001000);
        is_ori    = (opcode == 6'b001101);
        is_lw     = (opcode == 6'b100011);
        is_sw     = (opcode == 6'b101011);
        is_beq    = (opcode == 6'b000100);
        is_lui    = (opcode == 6'b001111);
        is_j      = (opcode == 6'b000010);
        is_jal    = (opcode == 6'b000011);
        supported = is_addu | is_subu | is_jr | is_ori | is_lw | is_sw |
                    is_beq | is_lui | is_j | is_jal;
    end

    // Extender control depends on opcode alone, independent of state.
    always_comb begin
        ExtOp = 2'b00;
        if (is_lw || is_sw) ExtOp = 2'b01;
        else if (is_lui)    ExtOp = 2'b10;
        else if (is_beq)    ExtOp = 2'b11;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // ---------------- next state / outputs ----------------
    always_comb begin
        // While in reset the outputs decode as FETCH; enables are masked below.
        st_eff  = reset ? state_q : S_FETCH;
        state_d = state_q;
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RegWr   = 1'b0;
        MemWr   = 1'b0;
        ALUOp   = 2'b00;
        ALUSrc  = 1'b0;
        RegDst  = 2'b00;
        WDSel   = 2'b00;
        NPCOp   = 2'b00;
        illegal = 1'b0;

        case (st_eff)
            S_FETCH: begin
                IRWr = rdy;
                PCWr = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_FETCH;
                if (is_j) begin
                    PCWr  = 1'b1;
                    NPCOp = 2'b10;
                end else if (is_jal) begin
                    PCWr   = 1'b1;
                    NPCOp  = 2'b10;
                    RegWr  = 1'b1;
                    RegDst = 2'b10;
                    WDSel  = 2'b10;
                end else if (is_jr) begin
                    PCWr  = 1'b1;
                    NPCOp = 2'b11;
                end else if (supported) begin
                    state_d = S_EXE;
                end else begin
                    illegal = 1'b1;  // executes as nop
                end
            end
            S_EXE: begin
                state_d = S_FETCH;
                if (is_beq) begin
                    ALUOp = 2'b01;
                    if (zero) begin
                        PCWr  = 1'b1;
                        NPCOp = 2'b01;
                    end
                end else if (is_addu) begin
                    state_d = S_WB;
                end else if (is_subu) begin
                    ALUOp   = 2'b01;
                    state_d = S_WB;
                end else if (is_ori) begin
                    ALUOp   = 2'b10;
                    ALUSrc  = 1'b1;
                    state_d = S_WB;
                end else if (is_lui) begin
                    ALUOp   = 2'b11;
                    ALUSrc  = 1'b1;
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    ALUSrc  = 1'b1;
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    MemWr = rdy;
                    if (rdy) state_d = S_FETCH;
                end else if (is_lw) begin
                    if (rdy) state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                RegWr   = 1'b1;
                RegDst  = is_r  ? 2'b01 : 2'b00;
                WDSel   = is_lw ? 2'b01 : 2'b00;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;  // unused codes recover with no enables
        endcase

        if (!reset) begin
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            RegWr   = 1'b0;
            MemWr   = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
// Each instruction class is described as a list of per-cycle expected output
// vectors; a random instruction stream is run against these lists.
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_rdy;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrc, illegal;
    logic [1:0] ExtOp, ALUOp, RegDst, WDSel, NPCOp;
    logic [2:0] state;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_rdy(mem_rdy),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .ExtOp(ExtOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
        .WDSel(WDSel), .NPCOp(NPCOp), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {PCWr,IRWr,RegWr,MemWr,ExtOp,ALUOp,ALUSrc,RegDst,WDSel,NPCOp,illegal,state}
    typedef logic [18:0] vec_t;

    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LW = 4,
                   C_SW = 5, C_BEQ = 6, C_LUI = 7, C_J = 8, C_JAL = 9,
                   C_ILL = 10;

    int   n_pass = 0;
    int   n_chk  = 0;
    vec_t prog[$];

    function automatic vec_t mk(int st, int pc, int ir, int rw, int mw,
                                int npc, int alu, int als, int rd, int wd,
                                int il);
        return {1'(pc), 1'(ir), 1'(rw), 1'(mw), 2'b00, 2'(alu), 1'(als),
                2'(rd), 2'(wd), 2'(npc), 1'(il), 3'(st)};
    endfunction

    function automatic logic [1:0] exp_ext(logic [5:0] op);
        case (op)
            6'b100011, 6'b101011: return 2'b01;
            6'b001111:            return 2'b10;
            6'b000100:            return 2'b11;
            default:              return 2'b00;
        endcase
    endfunction

    function automatic bit is_supported(logic [5:0] op, logic [5:0] fn);
        if (op == 6'b000000)
            return (fn == 6'b100001) || (fn == 6'b100011) || (fn == 6'b001000);
        return op inside {6'b001101, 6'b100011, 6'b101011, 6'b000100,
                          6'b001111, 6'b000010, 6'b000011};
    endfunction

    function automatic vec_t observed();
        return {PCWr, IRWr, RegWr, MemWr, ExtOp, ALUOp, ALUSrc, RegDst,
                WDSel, NPCOp, illegal, state};
    endfunction

    task automatic chk(string tag, vec_t exp_in);
        vec_t exp_v, got;
        exp_v = exp_in;
        exp_v[14:13] = exp_ext(opcode);
        got = observed();
        n_chk++;
        assert (got === exp_v) n_pass++;
        else $error("FAIL %s op=%b fn=%b got=%h exp=%h", tag, opcode, funct,
                    got, exp_v);
    endtask

    // Expected per-cycle behaviour of one instruction, FETCH through last state.
    task automatic build_prog(int cls, logic z);
        vec_t f, d;
        f = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        d = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        prog.delete();
        prog.push_back(f);
        case (cls)
            C_J:   prog.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0));
            C_JAL: prog.push_back(mk(1, 1, 0, 1, 0, 2, 0, 0, 2, 2, 0));
            C_JR:  prog.push_back(mk(1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0));
            C_ILL: prog.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            C_BEQ: begin
                prog.push_back(d);
                prog.push_back(mk(2, int'(z), 0, 0, 0, z ? 1 : 0, 1, 0, 0, 0, 0));
            end
            C_ADDU, C_SUBU: begin
                prog.push_back(d);
                prog.push_back(mk(2, 0, 0, 0, 0, 0, cls == C_SUBU ? 1 : 0, 0, 0, 0, 0));
                prog.push_back(mk(4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
            end
            C_ORI, C_LUI: begin
                prog.push_back(d);
                prog.push_back(mk(2, 0, 0, 0, 0, 0, cls == C_LUI ? 3 : 2, 1, 0, 0, 0));
                prog.push_back(mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            C_LW: begin
                prog.push_back(d);
                prog.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
                prog.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                prog.push_back(mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
            end
            default: begin  // C_SW
                prog.push_back(d);
                prog.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
                prog.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            end
        endcase
    endtask

    task automatic encode(int cls, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (cls)
            C_ADDU: begin op = 6'b000000; fn = 6'b100001; end
            C_SUBU: begin op = 6'b000000; fn = 6'b100011; end
            C_JR:   begin op = 6'b000000; fn = 6'b001000; end
            C_ORI:  op = 6'b001101;
            C_LW:   op = 6'b100011;
            C_SW:   op = 6'b101011;
            C_BEQ:  op = 6'b000100;
            C_LUI:  op = 6'b001111;
            C_J:    op = 6'b000010;
            C_JAL:  op = 6'b000011;
            default: begin
                op = 6'($urandom);
                while (is_supported(op, fn)) begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end
            end
        endcase
    endtask

    // Called just after a rising edge with the DUT in FETCH. Runs the first
    // nsteps cycles of the instruction (all of it when nsteps < 0).
    task automatic run_instr(string tag, int cls, logic z, logic [5:0] op,
                             logic [5:0] fn, int nsteps);
        int n;
        build_prog(cls, z);
        opcode = op;
        funct  = fn;
        zero   = z;
        n = (nsteps < 0) ? prog.size() : nsteps;
        for (int k = 0; k < n; k++) begin
`ifndef MC_CTRL_MEMRDY_EN
            mem_rdy = 1'($urandom);
`endif
            @(negedge clk);
            chk($sformatf("%s_c%0d", tag, k), prog[k]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        int         cls;
        logic       z;

        reset = 1'b0; opcode = 6'b001101; funct = 6'd0; zero = 1'b0;
        mem_rdy = 1'b1;

        // reset: enables off, FETCH decode
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(posedge clk); #1;
        reset = 1'b1;

        // directed instructions
        run_instr("ori",    C_ORI,  1'b0, 6'b001101, 6'd0, -1);
        run_instr("beq_z1", C_BEQ,  1'b1, 6'b000100, 6'd0, -1);
        run_instr("beq_z0", C_BEQ,  1'b0, 6'b000100, 6'd0, -1);
        run_instr("lw",     C_LW,   1'b0, 6'b100011, 6'd0, -1);
        run_instr("sw",     C_SW,   1'b0, 6'b101011, 6'd0, -1);
        run_instr("jal",    C_JAL,  1'b0, 6'b000011, 6'd0, -1);
        run_instr("ill_3f", C_ILL,  1'b0, 6'b111111, 6'd0, -1);
        run_instr("addu",   C_ADDU, 1'b0, 6'b000000, 6'b100001, -1);
        run_instr("ill_rf", C_ILL,  1'b0, 6'b000000, 6'b100000, -1);

        // reset asserted during MEM of sw
        run_instr("sw_pre", C_SW, 1'b0, 6'b101011, 6'd0, 3);
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        assert ({PCWr, IRWr, RegWr, MemWr, illegal} === 5'b0) n_pass++;
        else $error("FAIL rst_mem_en got=%b exp=00000",
                    {PCWr, IRWr, RegWr, MemWr, illegal});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mem_fetch", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        reset = 1'b1;
        run_instr("after_rst", C_J, 1'b0, 6'b000010, 6'd0, -1);

`ifdef MC_CTRL_MEMRDY_EN
        // FETCH stall while memory not ready
        opcode = 6'b001101;
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fetch_stall", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
        end
        mem_rdy = 1'b1;
        run_instr("ori_after_stall", C_ORI, 1'b0, 6'b001101, 6'd0, -1);
`endif

        // random instruction stream
        for (int i = 0; i < 300; i++) begin
            cls = int'($urandom_range(0, 10));
            z   = 1'($urandom);
            encode(cls, op, fn);
            run_instr($sformatf("rnd%0d", i), cls, z, op, fn, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-003 SHALL have ports opcode  input  6 and funct  input  6  instruction fields, driven from the instruction register and stable from DECODE onward.
REQ-004 SHALL have port zero  input  1  ALU equality flag for beq.
REQ-005 SHALL have port mem_rdy  input  1  memory ready; used only under MC_CTRL_MEMRDY_EN.
REQ-006 SHALL have outputs PCWr, IRWr, RegWr, MemWr  output  1 each  write enables: PC, IR, register file, data memory.
REQ-007 SHALL have port ExtOp  output  2  to the immediate extender: 00 zero-ext, 01 sign-ext, 10 imm16<<16, 11 sign-ext<<2.
REQ-008 SHALL have port ALUOp  output  2: 00 add, 01 sub, 10 or, 11 pass B. Port ALUSrc  output  1: 0 rt, 1 EXT.
REQ-009 SHALL have ports RegDst  output  2 (00 rt, 01 rd, 10 $31) and WDSel  output  2 (00 ALU, 01 mem, 10 PC).
REQ-010 SHALL have port NPCOp  output  2: 00 PC+4, 01 branch, 10 j/jal target, 11 rs.
REQ-011 SHALL have ports state  output  3 (current state) and illegal  output  1 (unsupported-instruction pulse).

Function
REQ-012 SHALL implement a registered FSM: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH next cycle with all enables 0.
REQ-013 SHALL decode: R-type 000000 with funct addu 100001, subu 100011, jr 001000; ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
REQ-014 FETCH SHALL assert IRWr=1, PCWr=1, NPCOp=00 and go to DECODE.
REQ-015 DECODE with j SHALL assert PCWr, NPCOp=10; with jal additionally RegWr, RegDst=10, WDSel=10; with jr PCWr, NPCOp=11; each then goes to FETCH.
REQ-016 DECODE with any other supported instruction SHALL go to EXE with no enables asserted.
REQ-017 DECODE with an unsupported opcode/funct SHALL pulse illegal=1 for that cycle, assert no enables, and go to FETCH (executes as nop).
REQ-018 EXE with beq SHALL set ALUOp=01, ALUSrc=0, assert PCWr with NPCOp=01 only if zero=1, and go to FETCH.
REQ-019 EXE: addu ALUOp=00, subu 01, both ALUSrc=0; ori ALUOp=10, ALUSrc=1; lui ALUOp=11, ALUSrc=1; these go to WB. lw/sw: ALUOp=00, ALUSrc=1, go to MEM.
REQ-020 MEM with sw SHALL assert MemWr=1 and go to FETCH; with lw SHALL go to WB.
REQ-021 WB SHALL assert RegWr=1; RegDst=01 for R-type, else 00; WDSel=01 for lw, else 00; then go to FETCH.
REQ-022 ExtOp SHALL be a function of opcode only, in every state: ori 00, lw/sw 01, lui 10, beq 11, all others 00.
REQ-023 Data-select outputs not specified for a state SHALL be 0; no enable SHALL be asserted outside the cases listed.
REQ-024 Cycles per instruction SHALL be: j/jal/jr 2, beq 3, sw 4, addu/subu/ori/lui 4, lw 5.

Reset
REQ-025 With reset=0 at a rising edge, state SHALL become FETCH regardless of current state, including mid-instruction.
REQ-026 While reset=0, PCWr, IRWr, RegWr, MemWr and illegal SHALL be 0; other outputs SHALL follow the decode of FETCH.

Configuration
REQ-027 With MC_CTRL_MEMRDY_EN defined, FETCH and MEM SHALL hold state while mem_rdy=0; IRWr/PCWr in FETCH and MemWr in MEM SHALL assert only in the cycle where mem_rdy=1.
REQ-028 Without MC_CTRL_MEMRDY_EN, mem_rdy SHALL be ignored and FETCH/MEM SHALL last exactly one cycle.

Verification
REQ-029 Release reset, opcode=001101 (ori) held -> state 0,1,2,4,0; ExtOp=00 throughout; RegWr=1 only in WB with RegDst=00.
REQ-030 beq (000100): zero=1 -> PCWr=1, NPCOp=01 in EXE; zero=0 -> PCWr=0; ExtOp=11; 3 cycles each.
REQ-031 lw (100011) -> states 0,1,2,3,4; WB has WDSel=01, ExtOp=01. sw (101011) -> MemWr=1 in MEM only, 4 cycles.
REQ-032 jal (000011) -> DECODE has PCWr=1, RegWr=1, RegDst=10, WDSel=10, NPCOp=10; next state FETCH. opcode=111111 -> illegal=1 for one cycle in DECODE, no enables.
REQ-033 Drive reset=0 during MEM of sw -> next state FETCH, MemWr=0 while reset=0; with MC_CTRL_MEMRDY_EN and mem_rdy=0 for 3 cycles in FETCH -> state holds at 0, IRWr=0 until mem_rdy=1.
